bus_gearbox_fifo: RTL and testbench
===================================

// Module: bus_gearbox_fifo
// PURPOSE
//  Width-converting bus FIFO: wide write beats of up to RATIO words in, one WORD_W word out per read.
//  Next generation of the 128->64 bus FIFO, generalised in word width, ratio and depth.
//  Adds partial beats, write back-pressure, a programmable almost-full level and sticky error flags.
//  Sits between the burst-master data path (writer) and the narrow consumer (reader).
// PARAMETERS
//  WORD_W        64   read word width, bits
//  RATIO         2    words per write beat (>=1); write bus is RATIO*WORD_W bits
//  DEPTH         32   storage in words; power of 2, multiple of RATIO, >= 2*RATIO
//  AFULL_THRESH  16   almost_full asserts when count >= AFULL_THRESH (1..DEPTH)
// PORTS
//  clk          in   1                  rising-edge clock
//  rst_n        in   1                  asynchronous active-low reset
//  wr_en        in   1                  write request
//  wr_data      in   RATIO*WORD_W       word i in bits [i*WORD_W +: WORD_W], word 0 first
//  wr_cnt       in   $clog2(RATIO+1)    valid words in beat (lanes 0..wr_cnt-1)
//  wr_ready     out  1                  comb: (DEPTH - count) >= RATIO
//  rd_en        in   1                  read request
//  rd_data      out  WORD_W             registered read word
//  rd_valid     out  1                  one-cycle pulse: rd_data updated this cycle
//  count        out  $clog2(DEPTH)+1    words stored
//  full         out  1                  count == DEPTH
//  almost_full  out  1                  count >= AFULL_THRESH
//  empty        out  1                  count == 0
//  overflow     out  1                  sticky: write rejected
//  underflow    out  1                  sticky: read while empty
//  clr_err      in   1                  sync clear of overflow/underflow
// BEHAVIOUR
//  - Reset (rst_n low, async): pointers, count, rd_data, rd_valid, overflow, underflow -> 0.
//    Memory contents not reset. Reset mid-burst discards all stored words.
//  - Write accepted when wr_en & wr_ready & wr_cnt != 0: lane i (i < wr_cnt) -> mem[(wptr+i) mod DEPTH];
//    wptr += wr_cnt, wraps mod DEPTH (natural pointer overflow). Lanes >= wr_cnt ignored.
//  - wr_cnt > RATIO is clamped to RATIO. wr_en with wr_cnt == 0 is a no-op, not an error.
//  - wr_en & !wr_ready & wr_cnt != 0: beat dropped, no state change except overflow <= 1.
//  - wr_ready is conservative: it drops when fewer than RATIO free words remain, even for partial beats.
//  - Read accepted when rd_en & !empty: rd_data <= mem[rptr] at that edge; rd_valid = 1 for the next cycle;
//    rptr += 1, wraps mod DEPTH. Latency rd_en -> rd_data/rd_valid: 1 cycle.
//  - rd_en & empty: no pointer change, rd_data holds, rd_valid = 0, underflow <= 1.
//  - rd_data holds its last value between reads.
//  - Simultaneous accepted write and read in one cycle: count <= count + wr_cnt - 1. Flags are computed
//    from the pre-edge count, so the read never sees the same-cycle write (no bypass). A read from
//    empty with a simultaneous write is an underflow.
//  - Flags full/almost_full/empty/wr_ready are combinational from the registered count.
//  - clr_err clears both sticky bits; a new error in the same cycle wins (bit stays 1).
//  - Invariant: 0 <= count <= DEPTH; count == (wptr - rptr) mod DEPTH except when full.
// TESTING
//  1 Reset: rst_n low mid-stream -> immediately count=0, empty=1, rd_data=0, rd_valid=0, errors=0.
//  2 Write 0x2222..2222_1111..1111 (cnt=2), 1 read -> rd_data=0x1111..1111, next read 0x2222..2222,
//    rd_valid 1 cycle after each rd_en; empty=1 after second read.
//  3 16 full beats -> count=32, full=1, wr_ready=0 from count 31; 17th beat dropped, overflow=1, count=32.
//  4 Partial beats cnt=1,2,1 -> count=4; 4 reads return words in lane order; 5th read -> underflow=1,
//    rd_data holds word 4.
//  5 Wrap: 24 words written/read repeatedly over 3 passes -> data order intact across rptr/wptr wrap.
//  6 count=5, write cnt=2 and read same cycle -> count=6, almost_full crosses 16 at correct edge;
//    clr_err with a concurrent bad read -> underflow stays 1.

Source files
------------

// File: rtl/bus_gearbox_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bus_gearbox_fifo: wide-in / narrow-out FIFO with partial write beats,      |
// | back-pressure, programmable almost-full and sticky error flags.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bus_gearbox_fifo #(
  parameter int WORD_W       = 64,
  parameter int RATIO        = 2,
  parameter int DEPTH        = 32,
  parameter int AFULL_THRESH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [RATIO*WORD_W-1:0]       wr_data,
  input  logic [$clog2(RATIO+1)-1:0]    wr_cnt,
  output logic                          wr_ready,
  input  logic                          rd_en,
  output logic [WORD_W-1:0]             rd_data,
  output logic                          rd_valid,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          almost_full,
  output logic                          empty,
  output logic                          overflow,
  output logic                          underflow,
  input  logic                          clr_err
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(RATIO + 1);
  localparam int CNTW = AW + 1;

  logic [WORD_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [WORD_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [CW-1:0]     n_wr;
  logic              wr_acc;
  logic              wr_drop;
  logic              rd_acc;
  logic              rd_bad;

  // Flags come straight from the registered count, so a same-cycle write is never visible to a read.
  assign empty       = (count_q == '0);
  assign full        = (count_q == CNTW'(DEPTH));
  assign almost_full = (count_q >= CNTW'(AFULL_THRESH));
  assign wr_ready    = (count_q <= CNTW'(DEPTH - RATIO));

  always_comb begin
    n_wr    = (wr_cnt > CW'(RATIO)) ? CW'(RATIO) : wr_cnt;
    wr_acc  = wr_en && wr_ready && (n_wr != '0);
    wr_drop = wr_en && !wr_ready && (n_wr != '0);
    rd_acc  = rd_en && !empty;
    rd_bad  = rd_en && empty;

    wptr_d      = wr_acc ? (wptr_q + AW'(n_wr)) : wptr_q;
    rptr_d      = rd_acc ? (rptr_q + AW'(1)) : rptr_q;
    count_d     = count_q + (wr_acc ? CNTW'(n_wr) : CNTW'(0)) - (rd_acc ? CNTW'(1) : CNTW'(0));
    rd_data_d   = rd_acc ? mem[rptr_q] : rd_data_q;
    rd_valid_d  = rd_acc;
    // A fresh error outranks a clear issued in the same cycle.
    overflow_d  = wr_drop || (overflow_q && !clr_err);
    underflow_d = rd_bad || (underflow_q && !clr_err);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage carries no reset; lanes past the beat's word count are left untouched.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int i = 0; i < RATIO; i++) begin
        if (i < int'(n_wr)) begin
          mem[wptr_q + AW'(i)] <= wr_data[i*WORD_W +: WORD_W];
        end
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_gearbox_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bus_gearbox_fifo: directed self-checking bench for bus_gearbox_fifo.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_bus_gearbox_fifo;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [127:0] wr_data = '0;
  logic [1:0]   wr_cnt = '0;
  logic         wr_ready;
  logic         rd_en = 1'b0;
  logic [63:0]  rd_data;
  logic         rd_valid;
  logic [5:0]   count;
  logic         full;
  logic         almost_full;
  logic         empty;
  logic         overflow;
  logic         underflow;
  logic         clr_err = 1'b0;

  int passed = 0;
  int total  = 0;

  bus_gearbox_fifo #(.WORD_W(64), .RATIO(2), .DEPTH(32), .AFULL_THRESH(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .wr_cnt(wr_cnt),
    .wr_ready(wr_ready), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .count(count), .full(full), .almost_full(almost_full), .empty(empty),
    .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mkw(input int k);
    return {4{16'(k)}};
  endfunction

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] c, input logic [63:0] w1, input logic [63:0] w0);
    wr_en = 1'b1; wr_cnt = c; wr_data = {w1, w0};
    tick();
    wr_en = 1'b0; wr_cnt = '0;
  endtask

  task automatic rd();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    total++; if (count !== 6'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else passed++;
    total++; if (rd_data !== 64'd0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else passed++;
    total++; if ({rd_valid, overflow, underflow} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {rd_valid, overflow, underflow}); else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    beat(2'd2, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111);
    total++; if (count !== 6'd2) $display("FAIL basic_count: got %0d want 2", count); else passed++;
    rd_en = 1'b1;
    tick();
    total++; if (rd_valid !== 1'b1 || rd_data !== 64'h1111_1111_1111_1111)
      $display("FAIL basic_rd0: got v=%b d=%h want v=1 d=1111111111111111", rd_valid, rd_data); else passed++;
    tick();
    rd_en = 1'b0;
    total++; if (rd_valid !== 1'b1 || rd_data !== 64'h2222_2222_2222_2222)
      $display("FAIL basic_rd1: got v=%b d=%h want v=1 d=2222222222222222", rd_valid, rd_data); else passed++;
    total++; if (empty !== 1'b1) $display("FAIL basic_empty: got %b want 1", empty); else passed++;
    tick();
    total++; if (rd_valid !== 1'b0 || rd_data !== 64'h2222_2222_2222_2222)
      $display("FAIL basic_hold: got v=%b d=%h want v=0 d=2222222222222222", rd_valid, rd_data); else passed++;
  endtask

  task automatic test_full();
    for (int b = 0; b < 16; b++) begin
      total++; if (wr_ready !== 1'b1) $display("FAIL full_ready_b%0d: got %b want 1", b, wr_ready); else passed++;
      beat(2'd2, mkw(101 + 2*b), mkw(100 + 2*b));
    end
    total++; if (count !== 6'd32 || full !== 1'b1 || wr_ready !== 1'b0 || almost_full !== 1'b1)
      $display("FAIL full_state: got cnt=%0d f=%b r=%b af=%b want 32 1 0 1", count, full, wr_ready, almost_full);
    else passed++;
    beat(2'd2, mkw(999), mkw(998));
    total++; if (overflow !== 1'b1 || count !== 6'd32)
      $display("FAIL full_drop: got ovf=%b cnt=%0d want 1 32", overflow, count); else passed++;
    rd();
    total++; if (rd_data !== mkw(100) || count !== 6'd31 || wr_ready !== 1'b0 || full !== 1'b0)
      $display("FAIL full_31: got d=%h cnt=%0d r=%b f=%b want %h 31 0 0", rd_data, count, wr_ready, full, mkw(100));
    else passed++;
  endtask

  task automatic test_reset_midstream();
    // One time unit after the read edge: rd_valid is high, FIFO holds 31 words.
    rst_n = 1'b0;
    #1;
    total++; if (count !== 6'd0 || empty !== 1'b1 || rd_data !== 64'd0 || rd_valid !== 1'b0)
      $display("FAIL async_reset: got cnt=%0d e=%b d=%h v=%b want 0 1 0 0", count, empty, rd_data, rd_valid);
    else passed++;
    total++; if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL async_reset_err: got ovf=%b udf=%b want 0 0", overflow, underflow); else passed++;
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_partial();
    beat(2'd1, mkw(16'hBAD), mkw(16'hA1));
    beat(2'd2, mkw(16'hA3), mkw(16'hA2));
    beat(2'd1, mkw(16'hBAD), mkw(16'hA4));
    total++; if (count !== 6'd4) $display("FAIL partial_count: got %0d want 4", count); else passed++;
    beat(2'd0, mkw(16'hBAD), mkw(16'hBAD));
    total++; if (count !== 6'd4 || overflow !== 1'b0)
      $display("FAIL partial_cnt0: got cnt=%0d ovf=%b want 4 0", count, overflow); else passed++;
    for (int k = 1; k <= 4; k++) begin
      rd();
      total++; if (rd_valid !== 1'b1 || rd_data !== mkw(16'hA0 + k))
        $display("FAIL partial_rd%0d: got v=%b d=%h want v=1 d=%h", k, rd_valid, rd_data, mkw(16'hA0 + k));
      else passed++;
    end
    rd();
    total++; if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_data !== mkw(16'hA4))
      $display("FAIL partial_udf: got u=%b v=%b d=%h want 1 0 %h", underflow, rd_valid, rd_data, mkw(16'hA4));
    else passed++;
  endtask

  task automatic test_wrap();
    for (int p = 0; p < 3; p++) begin
      for (int b = 0; b < 12; b++) beat(2'd2, mkw(1001 + 24*p + 2*b), mkw(1000 + 24*p + 2*b));
      total++; if (count !== 6'd24) $display("FAIL wrap_count_p%0d: got %0d want 24", p, count); else passed++;
      for (int k = 0; k < 24; k++) begin
        rd();
        total++; if (rd_data !== mkw(1000 + 24*p + k))
          $display("FAIL wrap_p%0d_w%0d: got %h want %h", p, k, rd_data, mkw(1000 + 24*p + k));
        else passed++;
      end
    end
    total++; if (empty !== 1'b1) $display("FAIL wrap_empty: got %b want 1", empty); else passed++;
  endtask

  task automatic test_concurrent();
    clr_err = 1'b1; rd_en = 1'b1;
    tick();
    total++; if (underflow !== 1'b1) $display("FAIL clr_vs_err: got %b want 1", underflow); else passed++;
    rd_en = 1'b0;
    tick();
    clr_err = 1'b0;
    total++; if (underflow !== 1'b0) $display("FAIL clr_err: got %b want 0", underflow); else passed++;
    rd_en = 1'b1;
    beat(2'd2, mkw(2001), mkw(2000));
    rd_en = 1'b0;
    total++; if (underflow !== 1'b1 || count !== 6'd2 || rd_valid !== 1'b0)
      $display("FAIL empty_rw: got u=%b cnt=%0d v=%b want 1 2 0", underflow, count, rd_valid); else passed++;
    beat(2'd2, mkw(2003), mkw(2002));
    beat(2'd1, mkw(16'hBAD), mkw(2004));
    rd_en = 1'b1;
    beat(2'd2, mkw(2006), mkw(2005));
    rd_en = 1'b0;
    total++; if (count !== 6'd6 || rd_valid !== 1'b1 || rd_data !== mkw(2000))
      $display("FAIL rw_same: got cnt=%0d v=%b d=%h want 6 1 %h", count, rd_valid, rd_data, mkw(2000)); else passed++;
    for (int b = 0; b < 4; b++) beat(2'd2, mkw(2008 + 2*b), mkw(2007 + 2*b));
    total++; if (count !== 6'd14 || almost_full !== 1'b0)
      $display("FAIL af_14: got cnt=%0d af=%b want 14 0", count, almost_full); else passed++;
    rd_en = 1'b1;
    beat(2'd2, mkw(2016), mkw(2015));
    rd_en = 1'b0;
    total++; if (count !== 6'd15 || almost_full !== 1'b0 || rd_data !== mkw(2001))
      $display("FAIL af_15: got cnt=%0d af=%b d=%h want 15 0 %h", count, almost_full, rd_data, mkw(2001)); else passed++;
    beat(2'd3, mkw(2018), mkw(2017));
    total++; if (count !== 6'd17 || almost_full !== 1'b1 || wr_ready !== 1'b1)
      $display("FAIL af_17_clamp: got cnt=%0d af=%b r=%b want 17 1 1", count, almost_full, wr_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_reset_midstream();
    test_partial();
    test_wrap();
    test_concurrent();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
